// File: rtl/ddr_lane_gearbox.sv
// ----------------------------------------------------------------------------
// ddr_lane_gearbox
//
// Lane demultiplexer for the DDR data interface. It gathers DEMUX consecutive
// NCH-lane input words into one wide group and queues completed groups in a
// small FIFO that has valid/ready backpressure. An input word flagged with
// in_sync restarts the group at slot 0. Groups that are cut short by a
// mid-group sync, or dropped because the FIFO is full, are reported as
// one-cycle pulses and counted in saturating counters.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   in_valid       in_data carries a word this cycle (no input backpressure)
//   in_sync        qualified by in_valid: this word starts a group
//   in_data        NCH lanes, lane i at [i*W +: W]
//   out_valid      FIFO holds at least one group
//   out_ready      downstream takes the head group
//   out_data       head group, slot k (k=0 oldest) at [k*NCH*W +: NCH*W]
//   fill_level     number of groups held in the FIFO
//   align_err      pulse: a sync arrived part way through a group
//   align_err_cnt  saturating count of align_err pulses
//   ovf            pulse: a completed group was dropped because the FIFO was full
//   ovf_cnt        saturating count of ovf pulses
// ----------------------------------------------------------------------------
module ddr_lane_gearbox #(
    parameter int NCH        = 5,
    parameter int W          = 14,
    parameter int DEMUX      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    input  logic                              in_sync,
    input  logic [NCH*W-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DEMUX*NCH*W-1:0]            out_data,
    output logic [$clog2(FIFO_DEPTH):0]       fill_level,
    output logic                              align_err,
    output logic [CNT_W-1:0]                  align_err_cnt,
    output logic                              ovf,
    output logic [CNT_W-1:0]                  ovf_cnt
);

    localparam int WORD_W = NCH * W;
    localparam int GRP_W  = DEMUX * WORD_W;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = (DEMUX > 1) ? $clog2(DEMUX) : 1;

    localparam logic [CW-1:0] LAST_SLOT = CW'(DEMUX - 1);
    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(FIFO_DEPTH);

    // Group assembly state.
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [DEMUX-1:0][WORD_W-1:0]   slots_q, slots_d;
    logic                           complete;

    // FIFO state; pointers carry one extra bit to tell full from empty.
    logic [GRP_W-1:0]               mem_q [FIFO_DEPTH];
    logic [AW:0]                    wr_ptr_q, wr_ptr_d;
    logic [AW:0]                    rd_ptr_q, rd_ptr_d;
    logic                           full, pop, push_ok, drop;

    // Status pulses and counters.
    logic                           align_err_q, align_err_d;
    logic                           ovf_q;
    logic [CNT_W-1:0]               align_cnt_q, ovf_cnt_q;

    // ------------------------------------------------------------------
    // Slot assembly. slots_d is the group as it will look after this
    // word, so on completion it is the full group to push.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the branches so no path
        // leaves it unassigned, which would infer a latch.
        slots_d     = slots_q;
        cnt_d       = cnt_q;
        complete    = 1'b0;
        align_err_d = 1'b0;
        if (in_valid) begin
            if (in_sync) begin
                slots_d[0]  = in_data;
                align_err_d = (cnt_q != '0);
                if (DEMUX == 1) begin
                    complete = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = CW'(1);
                end
            end else begin
                slots_d[cnt_q] = in_data;
                if (cnt_q == LAST_SLOT) begin
                    complete = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control. A full FIFO still accepts a group when the head is
    // leaving in the same cycle.
    // ------------------------------------------------------------------
    assign fill_level = wr_ptr_q - rd_ptr_q;
    assign out_valid  = (fill_level != '0);
    assign full       = (fill_level == DEPTH_L);
    assign pop        = out_valid && out_ready;
    assign push_ok    = complete && (!full || pop);
    assign drop       = complete && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Storage holds stale data after reset; gating with out_valid keeps
    // out_data at zero whenever the FIFO is empty.
    assign out_data = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    // ------------------------------------------------------------------
    // Control registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            align_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            align_cnt_q <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            align_err_q <= align_err_d;
            ovf_q       <= drop;
            if (align_err_d && (align_cnt_q != '1)) align_cnt_q <= align_cnt_q + 1'b1;
            if (drop && (ovf_cnt_q != '1))          ovf_cnt_q   <= ovf_cnt_q + 1'b1;
        end
    end

    // NOTE: the datapath storage has no reset; the slot counter and FIFO
    // pointers decide which entries are meaningful, so resetting the wide
    // data registers would add reset fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        slots_q <= slots_d;
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= slots_d;
    end

    assign align_err     = align_err_q;
    assign align_err_cnt = align_cnt_q;
    assign ovf           = ovf_q;
    assign ovf_cnt       = ovf_cnt_q;

endmodule
